// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one uart_tx byte transmitter between
// N_REQ byte producers. A winning byte is captured at grant, the transmitter
// is strobed for one cycle, and the block follows the transmitter busy flag
// through the frame before arbitrating again. A strobe that never raises
// busy within BUSY_TIMEOUT cycles sets the sticky o_error flag.
//
// Optional feature macro: UART_ARB_LOCK_EN
//   When defined, a byte sent with i_last = 0 locks the grant to its
//   requester until that requester sends a byte with i_last = 1 (or reset /
//   timeout), so multi-byte messages are never interleaved.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_data,
    input  logic [N_REQ-1:0]   i_last,
    output logic [N_REQ-1:0]   o_ack,
    output logic [N_REQ-1:0]   o_grant,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_act,
    input  logic               i_tx_busy,
    output logic               o_idle,
    output logic               o_error
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [PW-1:0]    PTR_RESET = PW'(N_REQ - 1);
    localparam logic [CW-1:0]    CNT_MAX   = CW'(BUSY_TIMEOUT);
    localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;        // last requester served
    logic [PW-1:0]    owner;      // requester of the transfer in flight
    logic [CW-1:0]    cnt;        // cycles spent waiting for busy to rise
    logic [CW-1:0]    cnt_inc;
    logic [N_REQ-1:0] req_eff;    // requests allowed to compete this cycle
    logic             win_found;
    logic [PW-1:0]    win_idx;

`ifdef UART_ARB_LOCK_EN
    logic locked;   // grant is held by ptr until its message ends
    logic last_q;   // end-of-message marker captured with the byte
`else
    logic unused_last;
    assign unused_last = ^i_last;
`endif

    // Saturating increment of the busy-rise timeout counter.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // Restrict the competing requests to the lock owner while a message is open.
    always_comb begin
        req_eff = i_req;
`ifdef UART_ARB_LOCK_EN
        if (locked) begin
            req_eff = i_req & (ONE << ptr);
        end
`endif
    end

    // Round-robin pick: first eligible request searching upward from ptr+1.
    always_comb begin
        int            cand;
        logic [PW-1:0] cand_idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        // Walk farthest-first so the nearest candidate is the final assignment.
        for (int d = N_REQ; d >= 1; d--) begin
            cand = int'(ptr) + d;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[PW-1:0];
            if (req_eff[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Control FSM; every output is a register driven from here.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        // NOTE: reset clears every control register, so no X can leak to the transmitter.
        if (!i_reset_n) begin
            state     <= IDLE;
            ptr       <= PTR_RESET;
            owner     <= '0;
            cnt       <= '0;
            o_ack     <= '0;
            o_grant   <= '0;
            o_tx_data <= '0;
            o_tx_act  <= 1'b0;
            o_idle    <= 1'b1;
            o_error   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            locked    <= 1'b0;
            last_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; the strobes default low for one-cycle pulses.
            o_ack    <= '0;
            o_tx_act <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found && !i_tx_busy) begin
                        owner     <= win_idx;
                        o_grant   <= ONE << win_idx;
                        o_tx_data <= i_data[{win_idx, 3'b000} +: 8];
`ifdef UART_ARB_LOCK_EN
                        last_q    <= i_last[win_idx];
`endif
                        o_idle    <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_tx_act <= 1'b1;
                    o_ack    <= o_grant;
                    ptr      <= owner;
                    cnt      <= '0;
`ifdef UART_ARB_LOCK_EN
                    locked   <= !last_q;
`endif
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt_inc == CNT_MAX) begin
                        cnt     <= cnt_inc;
                        o_error <= 1'b1;
                        o_grant <= '0;
                        o_idle  <= 1'b1;
`ifdef UART_ARB_LOCK_EN
                        locked  <= 1'b0;
`endif
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        o_grant <= '0;
                        o_idle  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_grant <= '0;
                    o_idle  <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// randomized message traffic, all checked against a queue-based model of the
// requesters, a simple transmitter model and a round-robin reference.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N_REQ        = 4;
    localparam int BUSY_TIMEOUT = 15;
    localparam int QD           = 64;

    logic               i_clock = 1'b0;
    logic               i_reset_n = 1'b0;
    logic [N_REQ-1:0]   i_req = '0;
    logic [8*N_REQ-1:0] i_data = '0;
    logic [N_REQ-1:0]   i_last = '0;
    logic [N_REQ-1:0]   o_ack;
    logic [N_REQ-1:0]   o_grant;
    logic [7:0]         o_tx_data;
    logic               o_tx_act;
    logic               i_tx_busy = 1'b0;
    logic               o_idle;
    logic               o_error;

    always #5 i_clock = ~i_clock;

    uart_tx_arbiter #(.N_REQ(N_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_req     (i_req),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_ack     (o_ack),
        .o_grant   (o_grant),
        .o_tx_data (o_tx_data),
        .o_tx_act  (o_tx_act),
        .i_tx_busy (i_tx_busy),
        .o_idle    (o_idle),
        .o_error   (o_error)
    );

    int n_asserts = 0;
    int n_fails   = 0;

    // Requester byte queues: {last, data}
    logic [8:0] qmem [N_REQ][QD];
    int         qh [N_REQ];
    int         qt [N_REQ];

    // Reference model state
    int   m_ptr;
    bit   m_lock;
    int   m_own;
    logic exp_error;
    int   ack_log[$];
    int   last_ack;

    // Transmitter model
    bit tx_auto;
    int tx_left;
    int frame_lo = 3;
    int frame_hi = 10;

    // Requests as seen at the last two rising edges (grant edge is two back at ack time)
    logic [N_REQ-1:0] req_h1 = '0, req_h2 = '0;
    always @(posedge i_clock) begin
        req_h2 <= req_h1;
        req_h1 <= i_req;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] mask, input int ptr);
        for (int d = 1; d <= N_REQ; d++) begin
            if (mask[(ptr + d) % N_REQ]) return (ptr + d) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int pending_total();
        int s = 0;
        for (int k = 0; k < N_REQ; k++) s += qt[k] - qh[k];
        return s;
    endfunction

    task automatic push(input int k, input logic [7:0] d, input logic last);
        qmem[k][qt[k] % QD] = {last, d};
        qt[k]++;
    endtask

    task automatic drive_inputs();
        logic [8*N_REQ-1:0] dv;
        logic [N_REQ-1:0]   rv, lv;
        dv = '0; rv = '0; lv = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (qt[k] > qh[k]) begin
                rv[k]        = 1'b1;
                dv[k*8 +: 8] = qmem[k][qh[k] % QD][7:0];
                lv[k]        = qmem[k][qh[k] % QD][8];
            end
        end
        i_req  = rv;
        i_data = dv;
        i_last = lv;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_REQ; k++) begin
            qh[k] = 0;
            qt[k] = 0;
        end
        m_ptr     = N_REQ - 1;
        m_lock    = 1'b0;
        m_own     = 0;
        exp_error = 1'b0;
        ack_log.delete();
    endtask

    task automatic reset_dut(input logic busy);
        i_reset_n = 1'b0;
        tx_auto   = 1'b0;
        tx_left   = 0;
        i_tx_busy = busy;
        model_reset();
        drive_inputs();
        repeat (3) @(negedge i_clock);
        i_reset_n = 1'b1;
    endtask

    // One clock: sample on the falling edge, check, then update the environment.
    task automatic step();
        int   k;
        int   exp_k;
        logic lst;
        @(negedge i_clock);
        last_ack = -1;
        check("act_while_busy", {31'd0, o_tx_act & i_tx_busy}, 32'd0);
        check("act_matches_ack", {31'd0, o_tx_act}, {31'd0, |o_ack});
        check("error_flag", {31'd0, o_error}, {31'd0, exp_error});
        if (o_ack != '0) begin
            k = -1;
            for (int j = 0; j < N_REQ; j++) if (o_ack[j] && k < 0) k = j;
            check("ack_onehot", $countones(o_ack), 1);
            exp_k = m_lock ? m_own : rr_pick(req_h2, m_ptr);
            check("winner", k, exp_k);
            check("grant_at_ack", {28'd0, o_grant}, 1 << k);
            if (qt[k] > qh[k]) begin
                check("tx_data", {24'd0, o_tx_data}, {24'd0, qmem[k][qh[k] % QD][7:0]});
                lst = qmem[k][qh[k] % QD][8];
                qh[k]++;
            end else begin
                check("ack_without_request", k, -1);
                lst = 1'b1;
            end
            ack_log.push_back(k);
            last_ack = k;
            m_ptr    = k;
`ifdef UART_ARB_LOCK_EN
            m_lock = !lst;
            m_own  = k;
`else
            lst = lst;
`endif
        end
        if (tx_auto) begin
            if (o_tx_act) begin
                i_tx_busy = 1'b1;
                tx_left   = $urandom_range(frame_hi, frame_lo);
            end else if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) i_tx_busy = 1'b0;
            end
        end
        drive_inputs();
    endtask

    task automatic wait_ack(input string tag, input int budget, output int lat);
        bit found = 1'b0;
        lat = 0;
        for (int n = 0; n < budget && !found; n++) begin
            step();
            lat++;
            if (last_ack >= 0) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pushed;
        int exp_fair[5] = '{0, 1, 2, 3, 0};
`ifdef UART_ARB_LOCK_EN
        int exp_lock[5] = '{2, 2, 2, 0, 1};
`else
        int exp_lock[5] = '{2, 0, 1, 2, 2};
`endif

        // Reset state
        reset_dut(1'b0);
        check("rst_ack",     {28'd0, o_ack},     32'd0);
        check("rst_grant",   {28'd0, o_grant},   32'd0);
        check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_act",     {31'd0, o_tx_act},  32'd0);
        check("rst_idle",    {31'd0, o_idle},    32'd1);
        check("rst_error",   {31'd0, o_error},   32'd0);

        // Single request, 2-cycle latency, grant held through the frame
        tx_auto = 1'b1;
        push(0, 8'h41, 1'b1);
        drive_inputs();
        wait_ack("single_wait", 10, lat);
        check("single_latency", lat, 2);
        check("single_id", last_ack, 0);
        check("single_data", {24'd0, o_tx_data}, 32'h41);
        for (int n = 0; n < 20 && i_tx_busy; n++) begin
            step();
            check("single_grant_held", {28'd0, o_grant}, 32'b0001);
        end
        step();
        check("single_grant_clear", {28'd0, o_grant}, 32'd0);
        check("single_idle", {31'd0, o_idle}, 32'd1);
        check("single_data_hold", {24'd0, o_tx_data}, 32'h41);

        // Fairness with all four requesting
        reset_dut(1'b0);
        tx_auto = 1'b1;
        push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1);
        push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
        push(0, 8'h14, 1'b1);
        drive_inputs();
        for (int n = 0; n < 300 && ack_log.size() < 5; n++) step();
        check("fair_count", ack_log.size(), 5);
        for (int i = 0; i < 5 && i < ack_log.size(); i++) check("fair_order", ack_log[i], exp_fair[i]);

        // Transmitter busy across reset release
        reset_dut(1'b1);
        push(1, 8'h22, 1'b1);
        drive_inputs();
        repeat (50) step();
        check("busy_hold_no_ack", ack_log.size(), 0);
        i_tx_busy = 1'b0;
        tx_auto   = 1'b1;
        wait_ack("busy_release_wait", 10, lat);
        check("busy_release_latency", lat, 2);
        check("busy_release_id", last_ack, 1);

        // Busy timeout: transmitter never answers
        reset_dut(1'b0);
        push(0, 8'h55, 1'b1);
        push(0, 8'h66, 1'b1);
        drive_inputs();
        wait_ack("timeout_first", 10, lat);
        repeat (BUSY_TIMEOUT - 1) step();
        exp_error = 1'b1;
        step();
        check("timeout_grant_clear", {28'd0, o_grant}, 32'd0);
        check("timeout_idle", {31'd0, o_idle}, 32'd1);
        wait_ack("timeout_second", 10, lat);
        check("timeout_second_id", last_ack, 0);
        repeat (BUSY_TIMEOUT + 2) step();
        check("timeout_sticky", {31'd0, o_error}, 32'd1);

        // Reset in the middle of a frame
        reset_dut(1'b0);
        tx_auto  = 1'b1;
        frame_lo = 8; frame_hi = 8;
        push(0, 8'h77, 1'b1);
        drive_inputs();
        wait_ack("midframe_wait", 10, lat);
        step();
        check("midframe_grant", {28'd0, o_grant}, 32'b0001);
        #2 i_reset_n = 1'b0;
        #1;
        check("async_rst_grant", {28'd0, o_grant}, 32'd0);
        check("async_rst_idle",  {31'd0, o_idle},  32'd1);
        check("async_rst_act",   {31'd0, o_tx_act}, 32'd0);
        tx_auto   = 1'b0;
        tx_left   = 0;
        i_tx_busy = 1'b1;
        model_reset();
        push(0, 8'h80, 1'b1);
        push(2, 8'h82, 1'b1);
        drive_inputs();
        @(negedge i_clock);
        i_reset_n = 1'b1;
        repeat (10) step();
        check("midframe_no_ack", ack_log.size(), 0);
        i_tx_busy = 1'b0;
        tx_auto   = 1'b1;
        frame_lo  = 3; frame_hi = 6;
        wait_ack("midframe_tie", 10, lat);
        check("midframe_tie_id", last_ack, 0);
        wait_ack("midframe_next", 30, lat);
        check("midframe_next_id", last_ack, 2);

        // Message lock (or plain round-robin without the macro)
        reset_dut(1'b0);
        tx_auto = 1'b1;
        push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
        drive_inputs();
        step();
        push(0, 8'hB0, 1'b1);
        push(1, 8'hB1, 1'b1);
        drive_inputs();
        for (int n = 0; n < 300 && ack_log.size() < 5; n++) step();
        check("lock_count", ack_log.size(), 5);
        for (int i = 0; i < 5 && i < ack_log.size(); i++) check("lock_order", ack_log[i], exp_lock[i]);

        // Randomized message traffic
        reset_dut(1'b0);
        tx_auto  = 1'b1;
        frame_lo = 2; frame_hi = 9;
        pushed   = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(7, 0) == 0) begin
                int k   = $urandom_range(N_REQ - 1, 0);
                int len = $urandom_range(3, 1);
                if (qt[k] - qh[k] < QD - 4) begin
                    for (int b = 0; b < len; b++) begin
                        push(k, 8'($urandom), (b == len - 1) ? 1'b1 : 1'b0);
                        pushed++;
                    end
                    drive_inputs();
                end
            end
            step();
        end
        for (int n = 0; n < 3000 && pending_total() > 0; n++) step();
        check("random_drained", pending_total(), 0);
        check("random_ack_count", ack_log.size(), pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one uart_tx byte transmitter between N_REQ byte producers (debug console, status reporter, etc.).
- Captures one byte from the winning requester and pulses the transmitter's start strobe.
- Tracks the transmitter's busy flag through start, frame and stop bit, then re-arbitrates.
- Sits between producer logic and the uart_tx instance; its outputs connect directly to the transmitter's i_data / i_act / o_busy.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 15, cycles to wait for transmitter busy to rise after a strobe before flagging an error.

Ports:
- i_clock, input, 1, single clock for the whole block.
- i_reset_n, input, 1, asynchronous active-low reset.
- i_req, input, N_REQ, per-requester byte-valid; held high until the matching o_ack.
- i_data, input, 8*N_REQ, requester k byte at [8k+7:8k]; stable while i_req[k] is high.
- i_last, input, N_REQ, end-of-message marker per requester; used only with the optional feature.
- o_ack, output, N_REQ, one-cycle pulse: byte of requester k accepted.
- o_grant, output, N_REQ, one-hot owner of the current transfer; 0 when idle.
- o_tx_data, output, 8, registered byte to the transmitter.
- o_tx_act, output, 1, one-cycle start strobe to the transmitter.
- i_tx_busy, input, 1, transmitter busy flag.
- o_idle, output, 1, high in IDLE.
- o_error, output, 1, sticky; set on busy timeout, cleared only by reset.

Behaviour:
Reset:
- All outputs 0 except o_idle = 1.
- State IDLE; round-robin pointer = N_REQ-1, so requester 0 has first priority.
- Reset asserted mid-transfer aborts immediately; the transmitter finishes its frame on its own.
- Before leaving IDLE after reset, the block waits for i_tx_busy = 0.

IDLE:
- Arbitrates only when any i_req is high and i_tx_busy = 0.
- Winner is the first set request searching from pointer+1 upward, modulo N_REQ.
- Same edge: latch o_grant and o_tx_data <= i_data[winner]; move to ISSUE.

ISSUE (exactly 1 cycle):
- o_tx_act = 1 and o_ack[winner] = 1 together.
- Pointer <= winner; timeout counter cleared; move to WAIT_BUSY.

WAIT_BUSY:
- i_tx_busy = 1 moves to WAIT_DONE.
- Counter reaches BUSY_TIMEOUT first: set o_error, clear o_grant, return to IDLE.
- Counter width is clog2(BUSY_TIMEOUT+1) and saturates.

WAIT_DONE:
- Hold o_grant until i_tx_busy = 0, then clear o_grant and go to IDLE.

Timing and handshake:
- Latency from i_req to o_tx_act is 2 cycles when the block is IDLE and the transmitter is free.
- Back-to-back bytes incur a 3-cycle gap after busy falls (IDLE, ISSUE, busy rise).
- The byte is captured at grant. A requester dropping i_req during ISSUE still gets its byte sent and o_ack pulsed.
- Requests arriving in non-IDLE states wait; no request is lost while held.
- Simultaneous requests are resolved purely by the pointer; each requester gets at most one byte per round while others are pending.
- o_tx_data holds its value after the transfer until the next grant.

Optional Feature:
Macro UART_ARB_LOCK_EN.
- Defined:
  - After a byte with i_last[winner] = 0, the grant is locked to that requester.
  - IDLE then considers only i_req[winner]; others wait even if pending.
  - The lock is released after a byte sent with i_last = 1, or on reset or timeout.
  - If the locked requester drops i_req, the arbiter waits indefinitely (intended message framing).
- Undefined:
  - i_last is ignored; arbitration is per byte.

Test Plan:
- Single request: i_req = 0001, i_data[7:0] = 8'h41, transmitter free -> o_tx_act and o_ack = 0001 two cycles later; o_tx_data = 8'h41; o_grant = 0001 until busy falls.
- Fairness: i_req = 1111 held, distinct bytes 8'h10..8'h13 -> acks in order 0,1,2,3,0; one strobe per frame; no strobe while i_tx_busy = 1.
- Transmitter busy at reset release: i_tx_busy = 1 for 50 cycles with i_req = 0010 -> no o_tx_act until busy = 0, then strobe within 2 cycles.
- Timeout: i_tx_busy tied 0, i_req = 0001 -> o_error = 1 on cycle BUSY_TIMEOUT after the strobe; o_grant cleared; next byte still issued; o_error remains 1.
- Reset mid-frame: assert i_reset_n = 0 during WAIT_DONE -> outputs cleared asynchronously; after release with busy high, no strobe until busy = 0; requester 0 wins a 0101 tie.
- Lock (UART_ARB_LOCK_EN): requester 2 sends 3 bytes with i_last = 0,0,1 while i_req = 0111 -> acks 2,2,2, then 0 (pointer after 2), then 1. Without the macro -> 2,0,1,2,2.
